sudoku_hole_punch: RTL and testbench
====================================

Name: sudoku_hole_punch

Overview:
- Consumes the LFSR random fields (rand_A, rand_B, rand_setup) and turns a solved 9x9 board into a puzzle by blanking randomly chosen cells.
- Requests random values, rejects out-of-range and already-blank coordinates, and issues write strobes to the board memory. It signals done when the target hole count is reached.
- Sits directly downstream of the LFSR RNG and upstream of the board RAM and the solver/checker FSM.

Parameters:
BASE_HOLES, 30, holes punched when rand_setup = 0
HOLE_STEP, 4, extra holes per rand_setup LSB (max target 30 + 7*4 = 58)
SETTLE, 2, clka cycles waited after a request pulse before sampling the rand inputs (covers RNG clkb output latch)
MAX_TRIES, 1023, total sample attempts allowed per run before abort (10-bit counter)

Ports:
clka  in  1  single system clock; all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse begins a punch run; ignored while busy
rand_A  in  4  random row candidate from RNG
rand_B  in  4  random column candidate from RNG
rand_setup  in  3  difficulty selector from RNG
gen_rand_flag  out  1  request pulse to RNG (one cycle per attempt)
cell_we  out  1  board RAM write strobe
cell_addr  out  7  row*9+col, range 0..80
cell_data  out  4  always 4'd0 (blank) when cell_we = 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of run
fail  out  1  sticky until next start; set when MAX_TRIES is exhausted
holes_made  out  7  cells blanked in current/last run

Behaviour:
- Reset (async, reset_n = 0): state = IDLE. All outputs are 0: gen_rand_flag, cell_we, cell_addr, cell_data, busy, done, fail, holes_made. Blank mask (81 bits), try counter, settle counter and target are all cleared. Reset mid-run abandons the run with no further writes.
- States: IDLE, REQ, WAIT, CHECK, WRITE, DONE.
- IDLE:
  - On start = 1: latch target = BASE_HOLES + rand_setup*HOLE_STEP (7-bit).
  - Clear mask, holes_made, tries and fail.
  - Go to REQ. busy = 1 from the next cycle.
- REQ: gen_rand_flag = 1 for exactly this cycle; tries += 1. Go to WAIT.
- WAIT: count SETTLE cycles. Then go to CHECK.
- CHECK: sample rand_A (row) and rand_B (col) in this cycle.
  - Valid when row <= 8, col <= 8 and mask[row*9+col] = 0.
  - Valid -> WRITE.
  - Invalid and tries < MAX_TRIES -> REQ.
  - Invalid and tries = MAX_TRIES -> set fail, go to DONE.
- WRITE:
  - cell_we = 1, cell_addr = row*9+col, cell_data = 0, each for one cycle.
  - Set the mask bit; holes_made += 1.
  - If holes_made (new value) = target -> DONE, else -> REQ.
- DONE: done = 1 for one cycle, busy drops to 0 in the same cycle. Go to IDLE. holes_made and fail hold until the next start.
- Address arithmetic: row*9 computed as (row<<3)+row; 7-bit result, no overflow for row, col <= 8.
- Latency per accepted cell: 1 (REQ) + SETTLE + 1 (CHECK) + 1 (WRITE) = 5 cycles at default.
- Boundary conditions:
  - start while busy: ignored.
  - start and reset_n low together: reset wins.
  - The tries counter saturates; it never wraps.
  - A repeated coordinate never produces a second write.
  - cell_we is never high outside WRITE.

Decomposition:
- Shared package sudoku_pkg holds:
  - GRID_N = 9 and CELLS = 81
  - the cell_addr_t (7-bit) and digit_t (4-bit) typedefs
  - the BLANK = 4'd0 constant
  - the state enum for this FSM
- One natural sub-module: cell_mask_81, an 81-bit set/clear/test register. Set on write, clear-all on start, combinational test port.

Test Plan:
- Reset: drive reset_n low mid-WRITE -> cell_we, busy and holes_made read 0 immediately (asynchronously); no write after release.
- Normal run: rand_setup = 0, RNG model supplies distinct valid (row, col) pairs -> exactly 30 writes. done pulses once, holes_made = 30, fail = 0, first write addr for (2,5) = 23.
- Rejection: feed rand_A = 9, then rand_B = 15, then (8,8) -> no write for the first two attempts, then one write to addr 80, with three gen_rand_flag pulses.
- Duplicate: feed (4,4) twice, then (0,0) -> writes to 40 and 0 only; addr 40 is never written twice.
- Max difficulty: rand_setup = 7 -> target 58, 58 writes, holes_made = 58.
- Abort: RNG stuck at (15,15) -> 1023 request pulses, then done with fail = 1, holes_made = 0, no cell_we. A later start clears fail.

Source files
------------

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sudoku_pkg
// Purpose  : Shared board geometry, cell typedefs and hole-punch FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

    localparam int GRID_N = 9;
    localparam int CELLS  = 81;

    typedef logic [6:0] cell_addr_t;
    typedef logic [3:0] digit_t;

    localparam digit_t BLANK = 4'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } hp_state_t;

    // row*9+col using a shift-add; exact for row, col <= 8
    function automatic cell_addr_t cell_index(input logic [3:0] row, input logic [3:0] col);
        cell_addr_t w_row7;
        w_row7 = {3'b000, row};
        return (w_row7 << 3) + w_row7 + {3'b000, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_mask_81.sv
`default_nettype none
// ============================================================================
// Module   : cell_mask_81
// Purpose  : 81-bit blank-cell mask with clear-all, single-bit set and a
//            combinational test port.
// Revision : 1.0 - initial release
// ============================================================================
module cell_mask_81
    import sudoku_pkg::*;
(
    input  logic       clka,
    input  logic       reset_n,
    input  logic       i_clr,
    input  logic       i_set,
    input  cell_addr_t i_set_addr,
    input  cell_addr_t i_test_addr,
    output logic       o_hit
);

    logic [CELLS-1:0] r_mask;

    // Clear has priority so a fresh run never inherits stale holes
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (i_clr) begin
            r_mask <= '0;
        end else if (i_set && (i_set_addr < 7'(CELLS))) begin
            r_mask[i_set_addr] <= 1'b1;
        end
    end

    // Out-of-range addresses read as not-blank; the caller rejects them anyway
    assign o_hit = (i_test_addr < 7'(CELLS)) ? r_mask[i_test_addr] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/sudoku_hole_punch.sv
`default_nettype none
// ============================================================================
// Module   : sudoku_hole_punch
// Purpose  : Blanks randomly chosen cells of a solved board until the target
//            hole count is reached; rejects off-board and repeated picks.
// Revision : 1.0 - initial release
// ============================================================================
module sudoku_hole_punch
    import sudoku_pkg::*;
#(
    parameter int BASE_HOLES = 30,
    parameter int HOLE_STEP  = 4,
    parameter int SETTLE     = 2,
    parameter int MAX_TRIES  = 1023
) (
    input  logic       clka,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [3:0] i_rand_A,
    input  logic [3:0] i_rand_B,
    input  logic [2:0] i_rand_setup,
    output logic       o_gen_rand_flag,
    output logic       o_cell_we,
    output cell_addr_t o_cell_addr,
    output digit_t     o_cell_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fail,
    output logic [6:0] o_holes_made
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    hp_state_t    r_state;
    logic [9:0]   r_tries;
    logic [SW-1:0] r_settle;
    logic [6:0]   r_target;
    logic [6:0]   r_holes;
    logic         r_gen;
    logic         r_we;
    cell_addr_t   r_addr;
    logic         r_busy;
    logic         r_done;
    logic         r_fail;

    logic         w_clr;
    logic         w_hit;
    cell_addr_t   w_addr;
    logic         w_valid;

    assign w_clr   = (r_state == S_IDLE) && i_start;
    assign w_addr  = cell_index(i_rand_A, i_rand_B);
    assign w_valid = (i_rand_A <= 4'd8) && (i_rand_B <= 4'd8) && !w_hit;

    cell_mask_81 u_mask (
        .clka        (clka),
        .reset_n     (reset_n),
        .i_clr       (w_clr),
        .i_set       (r_we),
        .i_set_addr  (r_addr),
        .i_test_addr (w_addr),
        .o_hit       (w_hit)
    );

    // Control FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_tries  <= '0;
            r_settle <= '0;
            r_target <= '0;
            r_holes  <= '0;
            r_gen    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_gen  <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_target <= 7'(BASE_HOLES) + 7'(i_rand_setup) * 7'(HOLE_STEP);
                        r_holes  <= '0;
                        r_tries  <= '0;
                        r_fail   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_gen    <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (r_tries != 10'(MAX_TRIES)) begin
                        r_tries <= r_tries + 10'd1;
                    end
                    r_settle <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_settle == SW'(SETTLE - 1)) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_valid) begin
                        r_we    <= 1'b1;
                        r_addr  <= w_addr;
                        r_state <= S_WRITE;
                    end else if (r_tries < 10'(MAX_TRIES)) begin
                        r_gen   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    r_holes <= r_holes + 7'd1;
                    if ((r_holes + 7'd1) == r_target) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_gen   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gen_rand_flag = r_gen;
    assign o_cell_we       = r_we;
    assign o_cell_addr     = r_addr;
    assign o_cell_data     = BLANK;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_fail          = r_fail;
    assign o_holes_made    = r_holes;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_hole_punch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sudoku_hole_punch
// Purpose  : Scoreboard bench: directed RNG vectors, expected write addresses
//            queued up front, monitor pops and compares on each cell_we.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sudoku_hole_punch;

    logic       clka;
    logic       reset_n;
    logic       i_start;
    logic [3:0] i_rand_A;
    logic [3:0] i_rand_B;
    logic [2:0] i_rand_setup;
    logic       o_gen_rand_flag;
    logic       o_cell_we;
    logic [6:0] o_cell_addr;
    logic [3:0] o_cell_data;
    logic       o_busy;
    logic       o_done;
    logic       o_fail;
    logic [6:0] o_holes_made;

    sudoku_hole_punch dut (
        .clka            (clka),
        .reset_n         (reset_n),
        .i_start         (i_start),
        .i_rand_A        (i_rand_A),
        .i_rand_B        (i_rand_B),
        .i_rand_setup    (i_rand_setup),
        .o_gen_rand_flag (o_gen_rand_flag),
        .o_cell_we       (o_cell_we),
        .o_cell_addr     (o_cell_addr),
        .o_cell_data     (o_cell_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_fail          (o_fail),
        .o_holes_made    (o_holes_made)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    logic [7:0] rng_q[$];   // {row, col} handed out one per request pulse
    int         exp_q[$];   // expected write addresses in order
    int n_checks = 0;
    int n_fail   = 0;
    int gen_cnt  = 0;
    int done_cnt = 0;
    int first_we_gen = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pair(input int c);
        return 8'(((c / 9) << 4) | (c % 9));
    endfunction

    // RNG model: a new pair appears after each request; empty queue = stuck at (15,15)
    initial begin
        logic [7:0] p;
        forever begin
            @(negedge clka);
            if (reset_n && o_gen_rand_flag) begin
                gen_cnt++;
                p = (rng_q.size() > 0) ? rng_q.pop_front() : 8'hFF;
                i_rand_A = p[7:4];
                i_rand_B = p[3:0];
            end
        end
    end

    // Monitor: every write must match the head of the expected queue
    initial begin
        int e;
        forever begin
            @(negedge clka);
            if (reset_n) begin
                if (o_cell_we) begin
                    if (first_we_gen < 0) first_we_gen = gen_cnt;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_addr", int'(o_cell_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", int'(o_cell_addr), e);
                        check("write_data", int'(o_cell_data), 0);
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    check("busy_low_with_done", int'(o_busy), 0);
                end
            end
        end
    end

    task automatic do_run(input logic [2:0] setup, input int exp_holes, input int exp_fail,
                          input int exp_gen, input int exp_cycles, input int poke_at,
                          input string tag);
        int cycles;
        gen_cnt = 0;
        done_cnt = 0;
        first_we_gen = -1;
        @(negedge clka);
        i_start = 1'b1;
        i_rand_setup = setup;
        @(negedge clka);
        i_start = 1'b0;
        check({tag, "_busy_after_start"}, int'(o_busy), 1);
        check({tag, "_fail_cleared"}, int'(o_fail), 0);
        cycles = 0;
        while (!o_done && cycles < 20000) begin
            @(negedge clka);
            cycles++;
            if (cycles == poke_at) begin
                i_start = 1'b1;
                i_rand_setup = 3'd7;
            end else if (cycles == poke_at + 1) begin
                i_start = 1'b0;
                i_rand_setup = setup;
            end
        end
        if (!o_done) check({tag, "_done_timeout"}, cycles, -1);
        if (exp_cycles >= 0) check({tag, "_run_cycles"}, cycles, exp_cycles);
        @(negedge clka);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_holes_made"}, int'(o_holes_made), exp_holes);
        check({tag, "_fail"}, int'(o_fail), exp_fail);
        check({tag, "_gen_pulses"}, gen_cnt, exp_gen);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_busy_idle"}, int'(o_busy), 0);
    endtask

    initial begin
        int cycles;
        reset_n = 1'b0;
        i_start = 1'b0;
        i_rand_A = 4'd0;
        i_rand_B = 4'd0;
        i_rand_setup = 3'd0;
        repeat (3) @(negedge clka);
        check("rst_gen", int'(o_gen_rand_flag), 0);
        check("rst_we", int'(o_cell_we), 0);
        check("rst_addr", int'(o_cell_addr), 0);
        check("rst_data", int'(o_cell_data), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_fail", int'(o_fail), 0);
        check("rst_holes", int'(o_holes_made), 0);
        reset_n = 1'b1;

        // Normal run: 30 distinct cells starting at (2,5)=23; stray start mid-run ignored
        for (int i = 0; i < 30; i++) begin
            rng_q.push_back(pair((23 + 7 * i) % 81));
            exp_q.push_back((23 + 7 * i) % 81);
        end
        do_run(3'd0, 30, 0, 30, 150, 40, "normal");

        // Rejection (row 9, col 15), then (8,8); duplicate (4,4); then (0,0) and odd cells
        rng_q = {8'h90, 8'h0F, 8'h88, 8'h44, 8'h44, 8'h00};
        exp_q = {80, 40, 0};
        for (int i = 0; i < 27; i++) begin
            rng_q.push_back(pair(1 + 2 * i));
            exp_q.push_back(1 + 2 * i);
        end
        do_run(3'd0, 30, 0, 33, -1, -1, "reject_dup");
        check("reject_first_write_after_pulses", first_we_gen, 3);

        // Maximum difficulty: 58 distinct cells
        for (int i = 0; i < 58; i++) begin
            rng_q.push_back(pair((5 + 11 * i) % 81));
            exp_q.push_back((5 + 11 * i) % 81);
        end
        do_run(3'd7, 58, 0, 58, -1, -1, "max");

        // Abort: RNG stuck at (15,15)
        do_run(3'd0, 0, 1, 1023, -1, -1, "abort");

        // Next start clears fail; async reset during the first write
        rng_q = {8'h33};
        exp_q = {30};
        @(negedge clka);
        i_start = 1'b1;
        i_rand_setup = 3'd0;
        @(negedge clka);
        i_start = 1'b0;
        check("restart_fail_cleared", int'(o_fail), 0);
        cycles = 0;
        while (!o_cell_we && cycles < 100) begin
            @(negedge clka);
            cycles++;
        end
        check("reset_run_reached_write", int'(o_cell_we), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_we", int'(o_cell_we), 0);
        check("async_rst_busy", int'(o_busy), 0);
        check("async_rst_holes", int'(o_holes_made), 0);
        repeat (3) @(negedge clka);
        check("reset_pending_writes", exp_q.size(), 0);
        rng_q.delete();
        reset_n = 1'b1;
        repeat (30) @(negedge clka);
        check("post_reset_busy", int'(o_busy), 0);
        check("post_reset_holes", int'(o_holes_made), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
